// File: rtl/fpu_norm_pack_if.sv
// Handshake bundle between the FPU add stage, the normalise/pack back end and its consumer.
// The slave side is the back end; the master side drives sums in and accepts packed words.
interface fpu_norm_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_sum;
    logic [9:0]  in_e;
    logic        in_s;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_ovf;
    logic        out_zero;

    modport slave (
        input  in_valid, in_sum, in_e, in_s, out_ready,
        output in_ready, out_valid, out_z, out_ovf, out_zero
    );

    modport master (
        output in_valid, in_sum, in_e, in_s, out_ready,
        input  in_ready, out_valid, out_z, out_ovf, out_zero
    );
endinterface

// File: rtl/fpu_norm_pack.sv
// FPU add back end: bit-serial normalisation, round-to-nearest-even and IEEE-754 single packing.
// One operation in flight; a new sum is accepted only from IDLE.
module fpu_norm_pack #(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 24,
    parameter int BIAS   = 127,
    parameter int EMIN   = -126
) (
    input logic           clk,
    input logic           rst_n,
    fpu_norm_pack_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADJ   = 3'd1,
        NORM1 = 3'd2,
        NORM2 = 3'd3,
        ROUND = 3'd4,
        PACK  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic signed [EXP_W-1:0] EMIN_V = EXP_W'(EMIN);
    localparam logic signed [EXP_W-1:0] EMAX_V = EXP_W'(BIAS);
    localparam logic signed [EXP_W-1:0] BIAS_V = EXP_W'(BIAS);
    localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);
    localparam logic [MANT_W-1:0]       M_ONE  = MANT_W'(1);
    localparam logic [MANT_W-1:0]       M_ALL  = {MANT_W{1'b1}};

    // Nearest-even: round up above the halfway point, or exactly at it when the LSB is odd.
    function automatic logic round_up(input logic guard, input logic rnd, input logic sticky,
                                      input logic lsb);
        return guard & (rnd | sticky | lsb);
    endfunction

    state_t                   state_r,  state_s;
    logic [MANT_W+3:0]        sum_r,    sum_s;
    logic [MANT_W-1:0]        mant_r,   mant_s;
    logic                     guard_r,  guard_s;
    logic                     round_r,  round_s;
    logic                     sticky_r, sticky_s;
    logic signed [EXP_W-1:0]  exp_r,    exp_s;
    logic                     sign_r,   sign_s;
    logic [31:0]              z_r,      z_s;
    logic                     ovf_r,    ovf_s;
    logic                     zero_r,   zero_s;
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic [EXP_W-1:0]         biased_s;
    logic [7:0]               exp8_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_z     = z_r;
    assign bus.out_ovf   = ovf_r;
    assign bus.out_zero  = zero_r;

    // State, datapath and output registers; handshake flags track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            sum_r       <= '0;
            mant_r      <= '0;
            guard_r     <= 1'b0;
            round_r     <= 1'b0;
            sticky_r    <= 1'b0;
            exp_r       <= '0;
            sign_r      <= 1'b0;
            z_r         <= 32'h0000_0000;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sum_r       <= sum_s;
            mant_r      <= mant_s;
            guard_r     <= guard_s;
            round_r     <= round_s;
            sticky_r    <= sticky_s;
            exp_r       <= exp_s;
            sign_r      <= sign_s;
            z_r         <= z_s;
            ovf_r       <= ovf_s;
            zero_r      <= zero_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Next-state and datapath update for each pipeline step.
    always_comb begin
        state_s  = state_r;
        sum_s    = sum_r;
        mant_s   = mant_r;
        guard_s  = guard_r;
        round_s  = round_r;
        sticky_s = sticky_r;
        exp_s    = exp_r;
        sign_s   = sign_r;
        z_s      = z_r;
        ovf_s    = ovf_r;
        zero_s   = zero_r;
        biased_s = exp_r + BIAS_V;
        exp8_s   = 8'h00;

        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    sum_s   = bus.in_sum;
                    exp_s   = bus.in_e;
                    sign_s  = bus.in_s;
                    state_s = ADJ;
                end else begin
                    state_s = IDLE;
                end
            end
            ADJ: begin
                if (sum_r[MANT_W+3]) begin
                    mant_s   = sum_r[MANT_W+3:4];
                    guard_s  = sum_r[3];
                    round_s  = sum_r[2];
                    sticky_s = sum_r[1] | sum_r[0];
                    exp_s    = exp_r + E_ONE;
                end else begin
                    mant_s   = sum_r[MANT_W+2:3];
                    guard_s  = sum_r[2];
                    round_s  = sum_r[1];
                    sticky_s = sum_r[0];
                end
                // An exact zero sum is always +0.
                if (sum_r == '0) begin
                    sign_s = 1'b0;
                end else begin
                    sign_s = sign_r;
                end
                state_s = NORM1;
            end
            NORM1: begin
                if (!mant_r[MANT_W-1] && (exp_r > EMIN_V)) begin
                    mant_s  = {mant_r[MANT_W-2:0], guard_r};
                    guard_s = round_r;
                    round_s = 1'b0;
                    exp_s   = exp_r - E_ONE;
                end else begin
                    state_s = NORM2;
                end
            end
            NORM2: begin
                // Denormalise towards EMIN; bits shifted out collect into guard/round/sticky.
                if (exp_r < EMIN_V) begin
                    exp_s    = exp_r + E_ONE;
                    mant_s   = mant_r >> 1;
                    guard_s  = mant_r[0];
                    round_s  = guard_r;
                    sticky_s = sticky_r | round_r;
                end else begin
                    state_s = ROUND;
                end
            end
            ROUND: begin
                if (round_up(guard_r, round_r, sticky_r, mant_r[0])) begin
                    mant_s = mant_r + M_ONE;
                    if (mant_r == M_ALL) begin
                        exp_s = exp_r + E_ONE;
                    end else begin
                        exp_s = exp_r;
                    end
                end else begin
                    mant_s = mant_r;
                end
                state_s = PACK;
            end
            PACK: begin
                if (exp_r > EMAX_V) begin
                    z_s    = {sign_r, 8'hFF, 23'h000000};
                    ovf_s  = 1'b1;
                    zero_s = 1'b0;
                end else begin
                    if ((exp_r == EMIN_V) && !mant_r[MANT_W-1]) begin
                        exp8_s = 8'h00;
                    end else begin
                        exp8_s = biased_s[7:0];
                    end
                    z_s    = {sign_r, exp8_s, mant_r[22:0]};
                    ovf_s  = 1'b0;
                    zero_s = (exp8_s == 8'h00) && (mant_r[22:0] == 23'h000000);
                end
                state_s = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_norm_pack.sv
// Directed-vector bench for fpu_norm_pack: result word, flags and latency per vector,
// plus output hold under back-pressure and reset in the middle of normalisation.
module tb_fpu_norm_pack;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fpu_norm_pack_if bus();

    fpu_norm_pack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] sum;
        logic [9:0]  e;
        logic        s;
        logic [31:0] z;
        logic        ovf;
        logic        zero;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Entered just after a rising edge; leaves just after the handshake edge of the result.
    task automatic run_vec(input vec_t v, input int hold);
        int guard;
        int cnt;
        logic [31:0] z_first;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({v.name, "_in_ready_wait"}, 32'(bus.in_ready), 32'd1);
        bus.in_sum   = v.sum;
        bus.in_e     = v.e;
        bus.in_s     = v.s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        cnt = 0;
        while (!bus.out_valid && cnt < 400) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({v.name, "_latency"}, 32'(cnt), 32'(v.lat));
        check({v.name, "_z"}, bus.out_z, v.z);
        check({v.name, "_ovf"}, 32'(bus.out_ovf), 32'(v.ovf));
        check({v.name, "_zero"}, 32'(bus.out_zero), 32'(v.zero));
        check({v.name, "_busy_in_ready"}, 32'(bus.in_ready), 32'd0);
        z_first = bus.out_z;
        // Back-pressure with a competing input offered; neither may disturb the result.
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 28'h1234567;
            bus.in_e     = 10'd3;
            @(posedge clk); #1;
            check({v.name, "_hold_z"}, bus.out_z, z_first);
            check({v.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({v.name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({v.name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({v.name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{28'h8000000, 10'd0,   1'b0, 32'h40000000, 1'b0, 1'b0, 5,   "one_plus_one"};
        vecs[1]  = '{28'h0000008, 10'd0,   1'b0, 32'h34000000, 1'b0, 1'b0, 28,  "lsb_only"};
        vecs[2]  = '{28'h0000000, 10'd0,   1'b1, 32'h00000000, 1'b0, 1'b1, 131, "exact_zero"};
        vecs[3]  = '{28'h7FFFFFC, 10'd0,   1'b0, 32'h40000000, 1'b0, 1'b0, 5,   "round_carry"};
        // 2^-130 is a denormal with fraction 2^19.
        vecs[4]  = '{28'h4000000, 10'h37E, 1'b0, 32'h00080000, 1'b0, 1'b0, 9,   "denormal"};
        vecs[5]  = '{28'h8000000, 10'd127, 1'b0, 32'h7F800000, 1'b1, 1'b0, 5,   "overflow"};
        vecs[6]  = '{28'h8000000, 10'd126, 1'b0, 32'h7F000000, 1'b0, 1'b0, 5,   "max_exp"};
        vecs[7]  = '{28'h4000004, 10'd0,   1'b0, 32'h3F800000, 1'b0, 1'b0, 5,   "tie_even"};
        vecs[8]  = '{28'h400000C, 10'd0,   1'b0, 32'h3F800002, 1'b0, 1'b0, 5,   "tie_odd"};
        vecs[9]  = '{28'h8000018, 10'd0,   1'b0, 32'h40000002, 1'b0, 1'b0, 5,   "carry_tie_odd"};
        vecs[10] = '{28'h4000000, 10'd0,   1'b1, 32'hBF800000, 1'b0, 1'b0, 5,   "neg_one"};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sum    = 28'h0;
        bus.in_e      = 10'd0;
        bus.in_s      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_z", bus.out_z, 32'h0);
        check("rst_ovf", 32'(bus.out_ovf), 32'd0);
        check("rst_zero", 32'(bus.out_zero), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], 0);
        end

        run_vec(vecs[0], 10);

        // Reset in the middle of the long zero normalisation.
        bus.in_sum   = 28'h0;
        bus.in_e     = 10'd0;
        bus.in_s     = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("mid_norm_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_z", bus.out_z, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_no_result", 32'(bus.out_valid), 32'd0);
        run_vec(vecs[8], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
